// File: rtl/i2s_rx.sv
// I2S receive deserializer for the codec ADC path.
// BCLK, LRCLK and SDATA are oversampled on the system clock, so no logic runs on BCLK itself.
// Each slot is framed by LRCLK edges, and the deserializer delivers left/right pairs over valid/ready.
// The slot counter is 6 bits wide, so SLOT_WIDTH may be at most 63 and must exceed DATA_WIDTH.
`timescale 1ns/1ps

module i2s_rx #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic                  bclk_i,
    input  logic                  lrclk_i,
    input  logic                  sdata_i,
    output logic [DATA_WIDTH-1:0] sample_l,
    output logic [DATA_WIDTH-1:0] sample_r,
    output logic                  valid,
    input  logic                  ready,
    output logic                  locked,
    output logic                  overrun,
    output logic                  frame_err
);

    localparam logic [5:0] C_DATA_WIDTH = 6'(DATA_WIDTH);
    localparam logic [5:0] C_SLOT_LAST  = 6'(SLOT_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_ALIGN,
        ST_LEFT,
        ST_RIGHT
    } state_t;

    logic                  r_bclk_s1, r_bclk_s2, r_bclk_d;
    logic                  r_lr_s1, r_lr_s2;
    logic                  r_sd_s1, r_sd_s2;
    logic                  r_lr_prev;
    logic [5:0]            r_slot_cnt;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [DATA_WIDTH-1:0] r_hold_l;
    state_t                r_state;
    state_t                w_state_next;
    logic                  w_bit_edge;
    logic                  w_boundary;
    logic                  w_slot_last;
    logic                  w_emit;
    logic                  w_load_l;
    logic                  w_frame_err;

    // Two-flop synchronizers on all pins, plus a delayed BCLK copy for rise detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bclk_s1 <= 1'b0;
            r_bclk_s2 <= 1'b0;
            r_bclk_d  <= 1'b0;
            r_lr_s1   <= 1'b0;
            r_lr_s2   <= 1'b0;
            r_sd_s1   <= 1'b0;
            r_sd_s2   <= 1'b0;
        end else begin
            r_bclk_s1 <= bclk_i;
            r_bclk_s2 <= r_bclk_s1;
            r_bclk_d  <= r_bclk_s2;
            r_lr_s1   <= lrclk_i;
            r_lr_s2   <= r_lr_s1;
            r_sd_s1   <= sdata_i;
            r_sd_s2   <= r_sd_s1;
        end
    end

    assign w_bit_edge  = r_bclk_s2 & ~r_bclk_d;
    assign w_boundary  = w_bit_edge & (r_lr_s2 ^ r_lr_prev);
    assign w_slot_last = (r_slot_cnt == C_SLOT_LAST);

    // The bit counter and shift register advance on BCLK rises; LRCLK history keeps tracking while disabled so re-lock is clean.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lr_prev  <= 1'b0;
            r_slot_cnt <= '0;
            r_shreg    <= '0;
            r_hold_l   <= '0;
        end else begin
            if (w_bit_edge) begin
                r_lr_prev <= r_lr_s2;
            end
            if (!en_i) begin
                r_slot_cnt <= '0;
                r_shreg    <= '0;
            end else if (w_boundary) begin
                r_slot_cnt <= '0;
            end else if (w_bit_edge) begin
                r_slot_cnt <= r_slot_cnt + 6'd1;
                if (r_slot_cnt < C_DATA_WIDTH) begin
                    r_shreg <= {r_shreg[DATA_WIDTH-2:0], r_sd_s2};
                end
            end
            if (w_load_l) begin
                r_hold_l <= r_shreg;
            end
        end
    end

    // The state register holds the frame alignment state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_ALIGN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: slot length is judged at each LRCLK boundary and on counter overflow.
    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        w_load_l     = 1'b0;
        w_frame_err  = 1'b0;
        if (!en_i) begin
            w_state_next = ST_ALIGN;
        end else begin
            case (r_state)
                ST_ALIGN: begin
                    if (w_boundary && !r_lr_s2) begin
                        w_state_next = ST_LEFT;
                    end
                end
                ST_LEFT: begin
                    if (w_boundary && r_lr_s2) begin
                        if (w_slot_last) begin
                            w_load_l     = 1'b1;
                            w_state_next = ST_RIGHT;
                        end else begin
                            w_frame_err  = 1'b1;
                            w_state_next = ST_ALIGN;
                        end
                    end else if (w_bit_edge && !w_boundary && w_slot_last) begin
                        w_frame_err  = 1'b1;
                        w_state_next = ST_ALIGN;
                    end
                end
                ST_RIGHT: begin
                    if (w_boundary && !r_lr_s2) begin
                        if (w_slot_last) begin
                            w_emit = 1'b1;
                        end else begin
                            w_frame_err = 1'b1;
                        end
                        w_state_next = ST_LEFT;
                    end else if (w_bit_edge && !w_boundary && w_slot_last) begin
                        w_frame_err  = 1'b1;
                        w_state_next = ST_ALIGN;
                    end
                end
                default: begin
                    w_state_next = ST_ALIGN;
                end
            endcase
        end
    end

    // One-entry output buffer and registered status pulses. If the buffer is full and not being accepted, the new pair is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_l  <= '0;
            sample_r  <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            frame_err <= w_frame_err;
            locked    <= (w_state_next == ST_LEFT) || (w_state_next == ST_RIGHT);
            if (w_emit) begin
                if (!valid || ready) begin
                    sample_l <= r_hold_l;
                    sample_r <= r_shreg;
                    valid    <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives I2S frames with BCLK = clk/32 and checks hand-computed results.
`timescale 1ns/1ps

module tb_i2s_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_i;
    logic        bclk_i;
    logic        lrclk_i;
    logic        sdata_i;
    logic        ready;
    logic [23:0] sample_l;
    logic [23:0] sample_r;
    logic        valid;
    logic        locked;
    logic        overrun;
    logic        frame_err;

    int totalChecks = 0;
    int badChecks   = 0;

    int cyc = 0;
    int riseCyc = 0;
    int slotStartCyc = 0;
    logic carryBit = 1'b0;

    int validRiseCnt = 0;
    int validFallCnt = 0;
    int validRiseCyc = 0;
    int lockRiseCyc  = 0;
    int overrunCnt   = 0;
    int ferrCnt      = 0;
    logic prevValid  = 1'b0;
    logic prevLocked = 1'b0;
    logic [23:0] capL = '0;
    logic [23:0] capR = '0;

    i2s_rx #(.DATA_WIDTH(24), .SLOT_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (en_i),
        .bclk_i    (bclk_i),
        .lrclk_i   (lrclk_i),
        .sdata_i   (sdata_i),
        .sample_l  (sample_l),
        .sample_r  (sample_r),
        .valid     (valid),
        .ready     (ready),
        .locked    (locked),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // The monitor records edges and pulse widths on the negative edge, away from DUT updates.
    always @(negedge clk) begin
        if (valid && !prevValid) begin
            validRiseCnt++;
            validRiseCyc = cyc;
            capL = sample_l;
            capR = sample_r;
        end
        if (!valid && prevValid) validFallCnt++;
        if (locked && !prevLocked) lockRiseCyc = cyc;
        if (overrun) overrunCnt++;
        if (frame_err) ferrCnt++;
        prevValid  = valid;
        prevLocked = locked;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalChecks++;
        if (obs !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic slotBit(input logic [23:0] d, input logic p, input int k);
        return (k < 24) ? d[23-k] : p;
    endfunction

    // One BCLK period: the low phase carries new LRCLK/SDATA, followed by the high phase. Optionally pulse ready in the emit cycle.
    task automatic driveBit(input logic lr, input logic sd, input logic pulseReady);
        bclk_i  = 1'b0;
        lrclk_i = lr;
        sdata_i = sd;
        repeat (16) @(negedge clk);
        bclk_i  = 1'b1;
        riseCyc = cyc;
        if (pulseReady) begin
            repeat (2) @(negedge clk);
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
            repeat (13) @(negedge clk);
        end else begin
            repeat (16) @(negedge clk);
        end
    endtask

    // Sends periods [jFrom, jTo) of an n-BCLK slot. Period 0 carries the previous slot's last bit.
    task automatic applyStimulus(input logic lr, input logic [23:0] data, input logic pad,
                                 input int n, input int jFrom, input int jTo, input logic pulseReady);
        for (int j = jFrom; j < jTo; j++) begin
            driveBit(lr, (j == 0) ? carryBit : slotBit(data, pad, j - 1), pulseReady && (j == 0));
            if (j == 0) slotStartCyc = riseCyc;
        end
        if (jTo == n) carryBit = slotBit(data, pad, n - 1);
    endtask

    task automatic sendSlot(input logic lr, input logic [23:0] data, input logic pad);
        applyStimulus(lr, data, pad, 32, 0, 32, 1'b0);
    endtask

    task automatic acceptPair(input string tag);
        ready = 1'b1;
        @(negedge clk);
        checkOutput(tag, {31'd0, valid}, 32'd0);
        ready = 1'b0;
    endtask

    initial begin
        int lStart;
        int vBase;
        int fBase;
        rst_n   = 1'b0;
        en_i    = 1'b1;
        ready   = 1'b0;
        bclk_i  = 1'b0;
        lrclk_i = 1'b1;
        sdata_i = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("rst_sample_l", {8'd0, sample_l}, 32'd0);
        checkOutput("rst_sample_r", {8'd0, sample_r}, 32'd0);
        checkOutput("rst_valid", {31'd0, valid}, 32'd0);
        checkOutput("rst_locked", {31'd0, locked}, 32'd0);
        checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("rst_frame_err", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic capture.
        sendSlot(1'b1, 24'h000000, 1'b0);
        checkOutput("align_unlocked", {31'd0, locked}, 32'd0);
        sendSlot(1'b0, 24'h123456, 1'b0);
        checkOutput("lock_latency", lockRiseCyc - slotStartCyc, 32'd3);
        sendSlot(1'b1, 24'hABCDEF, 1'b0);
        sendSlot(1'b0, 24'h000001, 1'b0);
        checkOutput("basic_valid_cnt", validRiseCnt, 32'd1);
        checkOutput("basic_valid_latency", validRiseCyc - slotStartCyc, 32'd3);
        checkOutput("basic_l", {8'd0, capL}, 32'h123456);
        checkOutput("basic_r", {8'd0, capR}, 32'hABCDEF);

        // Backpressure: second pair 000001/800000 is dropped.
        sendSlot(1'b1, 24'h800000, 1'b0);
        sendSlot(1'b0, 24'h0ABCDE, 1'b0);
        checkOutput("bp_overrun_cnt", overrunCnt, 32'd1);
        checkOutput("bp_valid_held", {31'd0, valid}, 32'd1);
        checkOutput("bp_l_held", {8'd0, sample_l}, 32'h123456);
        checkOutput("bp_r_held", {8'd0, sample_r}, 32'hABCDEF);
        acceptPair("bp_valid_drop");

        // Simultaneous accept and emit.
        sendSlot(1'b1, 24'h13579B, 1'b0);
        sendSlot(1'b0, 24'hFEDCBA, 1'b0);
        checkOutput("sim_first_l", {8'd0, capL}, 32'h0ABCDE);
        checkOutput("sim_first_r", {8'd0, capR}, 32'h13579B);
        vBase = validFallCnt;
        sendSlot(1'b1, 24'h02468A, 1'b0);
        applyStimulus(1'b0, 24'h3C3C3C, 1'b0, 32, 0, 32, 1'b1);
        checkOutput("sim_valid_cont", validFallCnt, vBase);
        checkOutput("sim_no_overrun", overrunCnt, 32'd1);
        checkOutput("sim_valid", {31'd0, valid}, 32'd1);
        checkOutput("sim_new_l", {8'd0, sample_l}, 32'hFEDCBA);
        checkOutput("sim_new_r", {8'd0, sample_r}, 32'h02468A);
        acceptPair("sim_accept");

        // Short left slot of 28 BCLKs.
        ready = 1'b1;
        sendSlot(1'b1, 24'h1A2B3C, 1'b0);
        applyStimulus(1'b0, 24'h111111, 1'b0, 28, 0, 28, 1'b0);
        checkOutput("short_prev_l", {8'd0, capL}, 32'h3C3C3C);
        checkOutput("short_prev_r", {8'd0, capR}, 32'h1A2B3C);
        vBase = validRiseCnt;
        fBase = ferrCnt;
        sendSlot(1'b1, 24'h222222, 1'b0);
        checkOutput("short_frame_err", ferrCnt - fBase, 32'd1);
        checkOutput("short_unlocked", {31'd0, locked}, 32'd0);
        checkOutput("short_no_valid", validRiseCnt, vBase);
        sendSlot(1'b0, 24'h55AA33, 1'b0);
        sendSlot(1'b1, 24'hC3C3C3, 1'b0);
        ready = 1'b0;
        sendSlot(1'b0, 24'h0F0F0F, 1'b0);
        checkOutput("recover_valid_cnt", validRiseCnt, vBase + 1);
        checkOutput("recover_l", {8'd0, capL}, 32'h55AA33);
        checkOutput("recover_r", {8'd0, capR}, 32'hC3C3C3);

        // Reset pulse mid right slot with a pair pending.
        checkOutput("pre_rst_locked", {31'd0, locked}, 32'd1);
        applyStimulus(1'b1, 24'h000000, 1'b0, 32, 0, 16, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("mid_rst_sample_l", {8'd0, sample_l}, 32'd0);
        checkOutput("mid_rst_sample_r", {8'd0, sample_r}, 32'd0);
        checkOutput("mid_rst_valid", {31'd0, valid}, 32'd0);
        checkOutput("mid_rst_locked", {31'd0, locked}, 32'd0);
        checkOutput("mid_rst_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
        applyStimulus(1'b1, 24'h000000, 1'b0, 32, 16, 32, 1'b0);
        sendSlot(1'b0, 24'h246813, 1'b0);
        lStart = slotStartCyc;
        checkOutput("rst_relock_latency", lockRiseCyc - lStart, 32'd3);
        sendSlot(1'b1, 24'h9ABCDE, 1'b0);
        applyStimulus(1'b0, 24'h5A5A5A, 1'b0, 32, 0, 10, 1'b0);
        checkOutput("rst_pair_l", {8'd0, capL}, 32'h246813);
        checkOutput("rst_pair_r", {8'd0, capR}, 32'h9ABCDE);

        // Drop en_i mid-frame with a pair pending.
        en_i = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("en_unlocked", {31'd0, locked}, 32'd0);
        checkOutput("en_valid_held", {31'd0, valid}, 32'd1);
        checkOutput("en_l_held", {8'd0, sample_l}, 32'h246813);
        checkOutput("en_r_held", {8'd0, sample_r}, 32'h9ABCDE);
        en_i = 1'b1;
        applyStimulus(1'b0, 24'h5A5A5A, 1'b0, 32, 10, 32, 1'b0);
        sendSlot(1'b1, 24'h777777, 1'b0);
        checkOutput("en_still_unlocked", {31'd0, locked}, 32'd0);

        // Sign extremes with padding bits set to one; this left slot is also the re-lock slot.
        sendSlot(1'b0, 24'h7FFFFF, 1'b1);
        lStart = slotStartCyc;
        checkOutput("en_relock_latency", lockRiseCyc - lStart, 32'd3);
        acceptPair("en_accept");
        vBase = validRiseCnt;
        sendSlot(1'b1, 24'h800000, 1'b1);
        sendSlot(1'b0, 24'h000000, 1'b0);
        checkOutput("ext_valid_cnt", validRiseCnt, vBase + 1);
        checkOutput("ext_l", {8'd0, capL}, 32'h7FFFFF);
        checkOutput("ext_r", {8'd0, capR}, 32'h800000);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
